// File: rtl/cache_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_controller_pkg
// Description : Shared types and constants for the two-way set-associative
//               write-through data cache (FSM states, data-memory window base,
//               way count, tag-width helper).
// Revision    : 1.0 - initial release
// ============================================================================
package cache_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_MISS = 2'd1,
        ST_WRITE   = 2'd2
    } state_t;

    // Data memory window starts here; cache addresses are offsets from it.
    localparam logic [31:0] DMEM_BASE = 32'd1024;
    localparam int          NUM_WAYS  = 2;
    // Highest offset bit that takes part in the tag.
    localparam int          ADDR_MSB  = 18;

    // Tag covers offset bits [ADDR_MSB : 2+idx_w].
    function automatic int tag_width(input int idx_w);
        return ADDR_MSB - 1 - idx_w;
    endfunction

    localparam int TAG_W_DEFAULT = tag_width(6);

endpackage
`default_nettype wire

// File: rtl/cache_set_array.sv
`default_nettype none
// ============================================================================
// Module      : cache_set_array
// Description : Storage for the two-way cache: valid/tag/data per way and one
//               LRU bit per set. Combinational lookup, synchronous writes,
//               asynchronous clear of valid and LRU bits.
// Ports       : i_idx/i_tag      - lookup set and tag
//               o_hit/o_hit_way/o_hit_data - lookup result
//               o_victim_way     - way to fill on a miss
//               i_wr_en/i_wr_way/i_wr_data - line write (valid=1, tag=i_tag)
//               i_lru_en/i_lru_val - LRU bit update for set i_idx
// Revision    : 1.0 - initial release
// ============================================================================
module cache_set_array
    import cache_controller_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int IDX_W = 6,
    parameter int TAG_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_hit,
    output logic             o_hit_way,
    output logic [31:0]      o_hit_data,
    output logic             o_victim_way,
    input  logic             i_wr_en,
    input  logic             i_wr_way,
    input  logic [31:0]      i_wr_data,
    input  logic             i_lru_en,
    input  logic             i_lru_val
);

    logic [NUM_WAYS-1:0] r_valid [SETS];
    logic [TAG_W-1:0]    r_tag   [SETS][NUM_WAYS];
    logic [31:0]         r_data  [SETS][NUM_WAYS];
    logic                r_lru   [SETS];

    logic w_hit0;
    logic w_hit1;

    assign w_hit0     = r_valid[i_idx][0] && (r_tag[i_idx][0] == i_tag);
    assign w_hit1     = r_valid[i_idx][1] && (r_tag[i_idx][1] == i_tag);
    assign o_hit      = w_hit0 | w_hit1;
    assign o_hit_way  = w_hit1;
    assign o_hit_data = w_hit1 ? r_data[i_idx][1] : r_data[i_idx][0];

    // Prefer empty ways before evicting the LRU way.
    assign o_victim_way = !r_valid[i_idx][0] ? 1'b0 :
                          !r_valid[i_idx][1] ? 1'b1 : r_lru[i_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_lru[s]   <= 1'b0;
            end
        end else begin
            if (i_wr_en) begin
                r_valid[i_idx][i_wr_way] <= 1'b1;
            end
            if (i_lru_en) begin
                r_lru[i_idx] <= i_lru_val;
            end
        end
    end

    // Tag and data need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_idx][i_wr_way]  <= i_tag;
            r_data[i_idx][i_wr_way] <= i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// Module      : cache_controller
// Description : Two-way set-associative, write-through, no-write-allocate
//               data cache between the MEM stage and the SRAM controller.
//               Read hits complete in the request cycle; read misses and all
//               stores go to SRAM while o_ready holds the pipeline frozen.
// Ports       : i_rd_en/i_wr_en/i_address/i_wdata - MEM-stage request
//               o_rdata/o_ready                    - load data, pipeline run
//               o_sram_*/i_sram_*                  - SRAM controller handshake
// Options     : CACHE_STATS_EN adds o_hit_count / o_miss_count read counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int SETS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rd_en,
    input  logic        i_wr_en,
    input  logic [31:0] i_address,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_sram_rd_en,
    output logic        o_sram_wr_en,
    output logic [31:0] o_sram_address,
    output logic [31:0] o_sram_wdata,
    input  logic [31:0] i_sram_rdata,
    input  logic        i_sram_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] o_hit_count,
    output logic [31:0] o_miss_count
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = tag_width(IDX_W);

    state_t r_state;
    state_t w_next;

    logic [31:0]      w_offset;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [14:0]      w_unused_bits;

    logic             w_hit;
    logic             w_hit_way;
    logic [31:0]      w_hit_data;
    logic             w_victim_way;
    logic             w_arr_wr_en;
    logic             w_arr_wr_way;
    logic [31:0]      w_arr_wr_data;
    logic             w_lru_en;
    logic             w_lru_val;

    assign w_offset      = i_address - DMEM_BASE;
    assign w_idx         = w_offset[2 +: IDX_W];
    assign w_tag         = w_offset[2+IDX_W +: TAG_W];
    assign w_unused_bits = {w_offset[31:ADDR_MSB+1], w_offset[1:0]};

    assign o_sram_address = i_address;
    assign o_sram_wdata   = i_wdata;

    cache_set_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk          (clk),
        .rst          (rst),
        .i_idx        (w_idx),
        .i_tag        (w_tag),
        .o_hit        (w_hit),
        .o_hit_way    (w_hit_way),
        .o_hit_data   (w_hit_data),
        .o_victim_way (w_victim_way),
        .i_wr_en      (w_arr_wr_en),
        .i_wr_way     (w_arr_wr_way),
        .i_wr_data    (w_arr_wr_data),
        .i_lru_en     (w_lru_en),
        .i_lru_val    (w_lru_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        o_ready       = 1'b1;
        o_rdata       = '0;
        o_sram_rd_en  = 1'b0;
        o_sram_wr_en  = 1'b0;
        w_arr_wr_en   = 1'b0;
        w_arr_wr_way  = w_victim_way;
        w_arr_wr_data = i_wdata;
        w_lru_en      = 1'b0;
        w_lru_val     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A store takes priority over a simultaneous load.
                if (i_wr_en) begin
                    o_sram_wr_en = 1'b1;
                    o_ready      = 1'b0;
                    w_next       = ST_WRITE;
                end else if (i_rd_en) begin
                    if (w_hit) begin
                        o_rdata   = w_hit_data;
                        w_lru_en  = 1'b1;
                        w_lru_val = ~w_hit_way;
                    end else begin
                        o_sram_rd_en = 1'b1;
                        o_ready      = 1'b0;
                        w_next       = ST_RD_MISS;
                    end
                end
            end
            ST_RD_MISS: begin
                o_sram_rd_en = 1'b1;
                o_ready      = i_sram_ready;
                if (i_sram_ready) begin
                    o_rdata       = i_sram_rdata;
                    w_arr_wr_en   = 1'b1;
                    w_arr_wr_way  = w_victim_way;
                    w_arr_wr_data = i_sram_rdata;
                    w_lru_en      = 1'b1;
                    w_lru_val     = ~w_victim_way;
                    w_next        = ST_IDLE;
                end
            end
            ST_WRITE: begin
                o_sram_wr_en = 1'b1;
                o_ready      = i_sram_ready;
                if (i_sram_ready) begin
                    // Write-through without allocation: only a hit touches the array.
                    if (w_hit) begin
                        w_arr_wr_en   = 1'b1;
                        w_arr_wr_way  = w_hit_way;
                        w_arr_wr_data = i_wdata;
                        w_lru_en      = 1'b1;
                        w_lru_val     = ~w_hit_way;
                    end
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

`ifdef CACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;
    logic        w_rd_req;

    assign w_rd_req = (r_state == ST_IDLE) && i_rd_en && !i_wr_en;

    // Misses count once, on the cycle that launches the SRAM read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_rd_req && w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_rd_req && !w_hit) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign o_hit_count  = r_hit_count;
    assign o_miss_count = r_miss_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cache_controller
// Description : Self-checking bench for cache_controller with a behavioural
//               cache/memory model, fixed-latency SRAM responder, directed
//               scenarios and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_controller;

    localparam int SETS = 64;
    localparam int LAT  = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = 32'd1024;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        ready;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ready;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    always #5 clk = ~clk;

    cache_controller #(.SETS(SETS)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_rd_en        (rd_en),
        .i_wr_en        (wr_en),
        .i_address      (address),
        .i_wdata        (wdata),
        .o_rdata        (rdata),
        .o_ready        (ready),
        .o_sram_rd_en   (sram_rd_en),
        .o_sram_wr_en   (sram_wr_en),
        .o_sram_address (sram_address),
        .o_sram_wdata   (sram_wdata),
        .i_sram_rdata   (sram_rdata),
        .i_sram_ready   (sram_ready)
`ifdef CACHE_STATS_EN
        ,
        .o_hit_count    (hit_count),
        .o_miss_count   (miss_count)
`endif
    );

    // ---------------- SRAM responder: done LAT cycles after request ---------
    logic [31:0] sram_mem [0:1023];
    logic [31:0] ref_mem  [0:1023];
    int          busy;

    function automatic logic [31:0] init_word(input int w);
        if (w == 256) return 32'hDEADBEEF;
        return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    assign sram_ready = (busy == LAT);
    assign sram_rdata = sram_mem[sram_address[11:2]];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 0;
        end else if ((sram_rd_en || sram_wr_en) && !sram_ready) begin
            busy <= busy + 1;
        end else begin
            busy <= 0;
        end
    end

    always @(posedge clk) begin
        if (!rst && sram_wr_en && sram_ready) sram_mem[sram_address[11:2]] <= sram_wdata;
    end

    // ---------------- behavioural cache model -------------------------------
    logic        m_valid [SETS][2];
    logic [10:0] m_tag   [SETS][2];
    logic [31:0] m_data  [SETS][2];
    logic        m_lru   [SETS];
    int          m_hits, m_misses;

    // ---------------- expectations for the compare process ------------------
    logic        exp_on = 1'b0;
    logic        exp_ready, exp_rd, exp_wr, exp_rdata_on;
    logic [31:0] exp_rdata;
    int          exp_hits, exp_misses;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_on) begin
            chk("ready", {31'd0, ready}, {31'd0, exp_ready});
            chk("sram_rd_en", {31'd0, sram_rd_en}, {31'd0, exp_rd});
            chk("sram_wr_en", {31'd0, sram_wr_en}, {31'd0, exp_wr});
            chk("sram_address", sram_address, address);
            chk("sram_wdata", sram_wdata, wdata);
            if (exp_rdata_on) chk("rdata", rdata, exp_rdata);
`ifdef CACHE_STATS_EN
            chk("hit_count", hit_count, exp_hits);
            chk("miss_count", miss_count, exp_misses);
`endif
        end
    end

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++) begin
            m_valid[s][0] = 1'b0;
            m_valid[s][1] = 1'b0;
            m_lru[s]      = 1'b0;
        end
        m_hits   = 0;
        m_misses = 0;
    endfunction

    // One MEM-stage transaction; returns model hit status and the load data
    // seen on the completing cycle.
    task automatic op(input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, output bit hit, output logic [31:0] got);
        logic [31:0] m;
        int          s, way, victim, ncyc;
        logic [10:0] t;
        m   = a - 32'd1024;
        s   = int'(m[7:2]);
        t   = m[18:8];
        hit = 1'b0;
        way = 0;
        got = '0;
        for (int w = 0; w < 2; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) begin hit = 1'b1; way = w; end
        rd_en   = rd;
        wr_en   = wr;
        address = a;
        wdata   = d;
        ncyc    = (wr || (rd && !hit)) ? LAT + 1 : 1;
        for (int k = 0; k < ncyc; k++) begin
            exp_ready    = (k == ncyc - 1);
            exp_rd       = rd && !wr && (ncyc > 1);
            exp_wr       = wr;
            exp_rdata_on = rd && !wr && (k == ncyc - 1);
            exp_rdata    = hit ? m_data[s][way] : ref_mem[a[11:2]];
            exp_hits     = m_hits;
            exp_misses   = m_misses + ((rd && !wr && !hit && k > 0) ? 1 : 0);
            exp_on       = 1'b1;
            @(negedge clk);
            if (k == ncyc - 1) got = rdata;
            @(posedge clk);
            #1;
        end
        exp_on = 1'b0;
        if (wr) begin
            ref_mem[a[11:2]] = d;
            if (hit) begin
                m_data[s][way] = d;
                m_lru[s]       = (way == 0);
            end
        end else if (rd) begin
            if (hit) begin
                m_hits++;
                m_lru[s] = (way == 0);
            end else begin
                victim = !m_valid[s][0] ? 0 : !m_valid[s][1] ? 1 : int'(m_lru[s]);
                m_valid[s][victim] = 1'b1;
                m_tag[s][victim]   = t;
                m_data[s][victim]  = ref_mem[a[11:2]];
                m_lru[s]           = (victim == 0);
                m_misses++;
            end
        end
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic reset_mid_miss(input logic [31:0] a);
        rd_en   = 1'b1;
        wr_en   = 1'b0;
        address = a;
        repeat (2) @(posedge clk);
        #2;
        rst   = 1'b1;
        rd_en = 1'b0;
        #1;
        chk("rst_mid_ready", {31'd0, ready}, 32'd1);
        chk("rst_mid_sram_rd_en", {31'd0, sram_rd_en}, 32'd0);
        chk("rst_mid_sram_wr_en", {31'd0, sram_wr_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    bit          h;
    logic [31:0] g;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram_mem[i] = init_word(i);
            ref_mem[i]  = init_word(i);
        end
        model_clear();

        #12;
        chk("reset_ready", {31'd0, ready}, 32'd1);
        chk("reset_sram_rd_en", {31'd0, sram_rd_en}, 32'd0);
        chk("reset_sram_wr_en", {31'd0, sram_wr_en}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Cold read then repeat hit.
        op(1, 0, 32'd1024, 0, h, g);
        chk("cold_1024_hit", {31'd0, h}, 32'd0);
        chk("cold_1024_data", g, 32'hDEADBEEF);
`ifdef CACHE_STATS_EN
        chk("cold_miss_count", miss_count, 32'd1);
`endif
        op(1, 0, 32'd1024, 0, h, g);
        chk("rpt_1024_hit", {31'd0, h}, 32'd1);
        chk("rpt_1024_data", g, 32'hDEADBEEF);
`ifdef CACHE_STATS_EN
        chk("rpt_hit_count", hit_count, 32'd1);
`endif

        // Three lines in set 0: third evicts 1024.
        op(1, 0, 32'd1280, 0, h, g);
        op(1, 0, 32'd1536, 0, h, g);
        chk("evict_1536_hit", {31'd0, h}, 32'd0);
        op(1, 0, 32'd1024, 0, h, g);
        chk("reread_1024_hit", {31'd0, h}, 32'd0);
        op(1, 0, 32'd1536, 0, h, g);
        chk("reread_1536_hit", {31'd0, h}, 32'd1);

        // Read and write together: handled as a store.
        op(1, 1, 32'd1024, 32'hCAFEF00D, h, g);
        chk("both_1024_hit", {31'd0, h}, 32'd1);
        op(1, 0, 32'd1024, 0, h, g);
        chk("after_both_data", g, 32'hCAFEF00D);

        // Write hit updates the cached line.
        op(1, 0, 32'd1028, 0, h, g);
        op(0, 1, 32'd1028, 32'h12345678, h, g);
        chk("wr_1028_hit", {31'd0, h}, 32'd1);
        op(1, 0, 32'd1028, 0, h, g);
        chk("rd_1028_hit", {31'd0, h}, 32'd1);
        chk("rd_1028_data", g, 32'h12345678);

        // Write miss does not allocate.
        op(0, 1, 32'd2048, 32'hA5A50001, h, g);
        chk("wr_2048_hit", {31'd0, h}, 32'd0);
        op(1, 0, 32'd2048, 0, h, g);
        chk("rd_2048_hit", {31'd0, h}, 32'd0);
        chk("rd_2048_data", g, 32'hA5A50001);

        // Reset in the middle of a miss wipes the cache.
        reset_mid_miss(32'd1040);
        op(1, 0, 32'd1028, 0, h, g);
        chk("post_rst_1028_hit", {31'd0, h}, 32'd0);

        // Randomized traffic over a small address footprint to force reuse.
        for (int n = 0; n < 300; n++) begin
            int          r;
            logic [31:0] a;
            r = int'($urandom_range(0, 9));
            a = 32'd1024 + ($urandom_range(0, 3) << 8) + ($urandom_range(0, 3) << 2)
                + $urandom_range(0, 3);
            if (r == 0)      op(0, 0, a, $urandom, h, g);
            else if (r <= 5) op(1, 0, a, $urandom, h, g);
            else if (r <= 8) op(0, 1, a, $urandom, h, g);
            else             op(1, 1, a, $urandom, h, g);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
